writeback_merge: RTL and testbench
==================================

// Module: writeback_merge
// PURPOSE
//   Downstream neighbour of the X (single-cycle ALU) and Y (4-stage multiply) execute pipes.
//   Merges both result streams onto the single register-file write port.
//   X results win the port; collided Y results wait in a small FIFO.
//   FIFO entries made stale by a younger X write are killed.
//   Raises a stall to Issue before the FIFO can overflow.
// PARAMETERS
//   DEPTH        8   Y-result FIFO entries (power of two, >=4)
//   STALL_THRESH 4   assert wb_is_stall when occupancy >= STALL_THRESH (covers Y in-flight)
// PORTS
//   clock           in   1   single clock, rising edge
//   reset           in   1   asynchronous, active-low
//   x_wb_regdest    in   5   X-pipe destination register
//   x_wb_writereg   in   1   X-pipe result valid / write request
//   x_wb_wbvalue    in   32  X-pipe result
//   y_wb_regdest    in   5   Y-pipe destination register
//   y_wb_writereg   in   1   Y-pipe result valid / write request
//   y_wb_wbvalue    in   32  Y-pipe result (low word)
//   wb_rf_regdest   out  5   register-file write address
//   wb_rf_writereg  out  1   register-file write enable
//   wb_rf_wbvalue   out  32  register-file write data
//   wb_is_stall     out  1   to Issue: stop launching Y ops
//   wb_overflow     out  1   sticky error: a Y result was dropped because the FIFO was full
// BEHAVIOUR
//   - Reset (reset==0, async): all outputs 0; FIFO empty; pointers and count 0; overflow cleared.
//   - All outputs are registered. A write selected in cycle t appears on wb_rf_* in cycle t+1.
//   - Register 0: a request with regdest==0 is discarded (never written, never queued).
//   - Port selection each cycle, in priority order:
//       1. X valid -> write X.
//       2. else FIFO non-empty -> write the FIFO head and pop it.
//       3. else Y valid -> write Y directly (bypass; not enqueued).
//       4. else wb_rf_writereg=0; regdest and value hold their last values.
//   - Enqueue: Y valid and not consumed by case 3 -> push Y at the tail.
//     This includes the case where Y arrives while the FIFO is non-empty, so order is preserved.
//   - Age rule: X issues 1 cycle before writeback; Y issues 4 cycles before writeback.
//     Any X arriving now is therefore younger than every queued Y entry and than the Y arriving now.
//   - Kill rule (WAW): when X is valid with regdest r != 0:
//       - every FIFO entry with regdest r is invalidated;
//       - an incoming Y with regdest r is dropped.
//     Invalidated entries stay in place and are popped silently when they reach the head.
//     A silent pop takes a cycle with no write and no pop of another entry.
//   - Occupancy counts invalid entries until they are popped.
//   - Push and pop in the same cycle: count is unchanged, and the push is legal even when count==DEPTH.
//   - Full and push without pop: the Y result is dropped and wb_overflow is set.
//     wb_overflow stays set until reset.
//   - Pointers wrap modulo DEPTH; count is a $clog2(DEPTH)+1 bit field.
//   - wb_is_stall is registered from count: asserted in the cycle after count >= STALL_THRESH.
//   - Reset mid-operation: queued results are lost; no write is issued in the reset-release cycle.
// STRUCTURE
//   - Shared package: REG_W=5, DATA_W=32, REG_ZERO=5'd0, and the wb request struct
//     {valid, regdest, value}, also used by the execute pipes.
//   - One sub-module, wb_kill_fifo: DEPTH-entry FIFO with per-entry valid bits and a parallel
//     regdest compare/invalidate port. Top level holds the priority mux, output registers and stall.
// TESTING
//   - X only, r5=0x11 in cycle 0 -> wb_rf_writereg=1, regdest=5, value=0x11 in cycle 1.
//   - X r3=0xA and Y r4=0xB in the same cycle -> r3 written at t+1, r4 written at t+2,
//     and the FIFO is empty afterwards.
//   - Y r7=1 queued behind X, then X r7=2 the next cycle -> only r7=2 is written.
//     The killed entry pops silently and r7 is never overwritten with 1.
//   - X valid every cycle for 6 cycles with 6 distinct Y results (r1..r6)
//     -> wb_is_stall rises when count reaches 4.
//     Then r1..r6 drain in order once X stops.
//   - Fill FIFO to DEPTH=8 with X held valid, then push 1 more Y -> wb_overflow=1 and count stays 8.
//     After draining, wb_overflow is still 1.
//   - Y to r0 and X to r0 -> no write, no enqueue.
//     Separately, assert reset with 3 entries queued -> all outputs 0 and no writes after release.

Source files
------------

// File: rtl/writeback_merge_pkg.sv
// rtl/writeback_merge_pkg.sv - shared writeback request types and widths
package writeback_merge_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  regdest;
        logic [DATA_W-1:0] value;
    } wb_req_t;

    // r0 is hardwired, so a request aimed at it is never a real write
    function automatic logic is_write(input wb_req_t req);
        return req.valid && (req.regdest != REG_ZERO);
    endfunction

endpackage

// File: rtl/writeback_merge_kill_fifo.sv
// rtl/writeback_merge_kill_fifo.sv - Y-result FIFO with per-entry valid bits and regdest kill
module wb_kill_fifo
    import writeback_merge_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [REG_W-1:0]  push_regdest,
    input  logic [DATA_W-1:0] push_value,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [REG_W-1:0]  kill_regdest,
    output logic              head_valid,
    output logic [REG_W-1:0]  head_regdest,
    output logic [DATA_W-1:0] head_value,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
);

    logic [DEPTH-1:0]  ent_valid;
    logic [REG_W-1:0]  ent_reg [DEPTH];
    logic [DATA_W-1:0] ent_val [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (ent_reg[i] == kill_regdest))
                    ent_valid[i] <= 1'b0;
            end
            if (pop)
                ent_valid[rd_ptr] <= 1'b0;
            // Push comes last so a slot freed by a same-cycle pop is revalidated
            if (push)
                ent_valid[wr_ptr] <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            ent_reg[wr_ptr] <= push_regdest;
            ent_val[wr_ptr] <= push_value;
        end
    end

    assign head_valid   = ent_valid[rd_ptr];
    assign head_regdest = ent_reg[rd_ptr];
    assign head_value   = ent_val[rd_ptr];
    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));

endmodule

// File: rtl/writeback_merge.sv
// rtl/writeback_merge.sv - merges X and Y execute results onto one register-file write port
module writeback_merge
    import writeback_merge_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int STALL_THRESH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_W-1:0]  x_wb_regdest,
    input  logic              x_wb_writereg,
    input  logic [DATA_W-1:0] x_wb_wbvalue,
    input  logic [REG_W-1:0]  y_wb_regdest,
    input  logic              y_wb_writereg,
    input  logic [DATA_W-1:0] y_wb_wbvalue,
    output logic [REG_W-1:0]  wb_rf_regdest,
    output logic              wb_rf_writereg,
    output logic [DATA_W-1:0] wb_rf_wbvalue,
    output logic              wb_is_stall,
    output logic              wb_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LVL = CW'(STALL_THRESH);

    wb_req_t           x_req, y_req, sel;
    logic              x_wr, y_wr, y_bypass, y_enq;
    logic              fifo_push, fifo_pop, y_drop;
    logic              head_valid, fifo_empty, fifo_full;
    logic [REG_W-1:0]  head_regdest;
    logic [DATA_W-1:0] head_value;
    logic [CW-1:0]     fifo_count;

    assign x_req = '{valid: x_wb_writereg, regdest: x_wb_regdest, value: x_wb_wbvalue};
    assign y_req = '{valid: y_wb_writereg, regdest: y_wb_regdest, value: y_wb_wbvalue};
    assign x_wr  = is_write(x_req);
    // A same-cycle X to the same register is younger, so that Y is dead on arrival
    assign y_wr  = is_write(y_req) && !(x_wr && (y_req.regdest == x_req.regdest));

    always_comb begin
        sel       = '{valid: 1'b0, regdest: x_req.regdest, value: x_req.value};
        fifo_pop  = 1'b0;
        y_bypass  = 1'b0;
        if (x_wr) begin
            sel = x_req;
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sel      = '{valid: head_valid, regdest: head_regdest, value: head_value};
        end else if (y_wr) begin
            y_bypass = 1'b1;
            sel      = y_req;
        end
        y_enq     = y_wr && !y_bypass;
        fifo_push = y_enq && (!fifo_full || fifo_pop);
        y_drop    = y_enq && fifo_full && !fifo_pop;
    end

    wb_kill_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push         (fifo_push),
        .push_regdest (y_req.regdest),
        .push_value   (y_req.value),
        .pop          (fifo_pop),
        .kill_en      (x_wr),
        .kill_regdest (x_req.regdest),
        .head_valid   (head_valid),
        .head_regdest (head_regdest),
        .head_value   (head_value),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .count        (fifo_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_rf_writereg <= 1'b0;
            wb_rf_regdest  <= '0;
            wb_rf_wbvalue  <= '0;
            wb_is_stall    <= 1'b0;
            wb_overflow    <= 1'b0;
        end else begin
            wb_rf_writereg <= sel.valid;
            if (sel.valid) begin
                wb_rf_regdest <= sel.regdest;
                wb_rf_wbvalue <= sel.value;
            end
            if (y_drop)
                wb_overflow <= 1'b1;
            wb_is_stall <= (fifo_count >= STALL_LVL);
        end
    end

endmodule

// File: tb/tb_writeback_merge.sv
// tb/tb_writeback_merge.sv - directed scoreboard bench for writeback_merge
module tb_writeback_merge;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  x_wb_regdest = '0;
    logic        x_wb_writereg = 1'b0;
    logic [31:0] x_wb_wbvalue = '0;
    logic [4:0]  y_wb_regdest = '0;
    logic        y_wb_writereg = 1'b0;
    logic [31:0] y_wb_wbvalue = '0;
    logic [4:0]  wb_rf_regdest;
    logic        wb_rf_writereg;
    logic [31:0] wb_rf_wbvalue;
    logic        wb_is_stall;
    logic        wb_overflow;

    typedef struct {
        logic        we;
        logic [4:0]  r;
        logic [31:0] v;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    string       phase = "reset";
    logic [4:0]  last_r = '0;
    logic [31:0] last_v = '0;

    writeback_merge #(.DEPTH(8), .STALL_THRESH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .x_wb_regdest   (x_wb_regdest),
        .x_wb_writereg  (x_wb_writereg),
        .x_wb_wbvalue   (x_wb_wbvalue),
        .y_wb_regdest   (y_wb_regdest),
        .y_wb_writereg  (y_wb_writereg),
        .y_wb_wbvalue   (y_wb_wbvalue),
        .wb_rf_regdest  (wb_rf_regdest),
        .wb_rf_writereg (wb_rf_writereg),
        .wb_rf_wbvalue  (wb_rf_wbvalue),
        .wb_is_stall    (wb_is_stall),
        .wb_overflow    (wb_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, record the expected port state after the edge, then compare
    task automatic step(input logic xw, input logic [4:0] xr, input logic [31:0] xv,
                        input logic yw, input logic [4:0] yr, input logic [31:0] yv,
                        input logic ew, input logic [4:0] er, input logic [31:0] ev);
        exp_t e;
        x_wb_writereg = xw; x_wb_regdest = xr; x_wb_wbvalue = xv;
        y_wb_writereg = yw; y_wb_regdest = yr; y_wb_wbvalue = yv;
        if (ew) begin
            last_r = er;
            last_v = ev;
        end
        e = '{we: ew, r: last_r, v: last_v};
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check("writereg", 32'(wb_rf_writereg), 32'(e.we));
        check("regdest", 32'(wb_rf_regdest), 32'(e.r));
        check("wbvalue", wb_rf_wbvalue, e.v);
    endtask

    task automatic idle(input logic ew, input logic [4:0] er, input logic [31:0] ev);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ew, er, ev);
    endtask

    task automatic check_all_zero();
        check("rst_writereg", 32'(wb_rf_writereg), 32'd0);
        check("rst_regdest", 32'(wb_rf_regdest), 32'd0);
        check("rst_wbvalue", wb_rf_wbvalue, 32'd0);
        check("rst_stall", 32'(wb_is_stall), 32'd0);
        check("rst_overflow", 32'(wb_overflow), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_all_zero();
        reset = 1'b1;

        phase = "x_only";
        step(1, 5'd5, 32'h11, 0, 5'd0, 32'h0, 1, 5'd5, 32'h11);

        phase = "x_y_collide";
        step(1, 5'd3, 32'hA, 1, 5'd4, 32'hB, 1, 5'd3, 32'hA);
        idle(1, 5'd4, 32'hB);
        idle(0, 5'd0, 32'h0);

        phase = "waw_kill";
        step(1, 5'd2, 32'h20, 1, 5'd7, 32'h1, 1, 5'd2, 32'h20);
        step(1, 5'd7, 32'h2, 0, 5'd0, 32'h0, 1, 5'd7, 32'h2);
        idle(0, 5'd0, 32'h0);
        idle(0, 5'd0, 32'h0);

        phase = "stall";
        for (int k = 0; k < 6; k++) begin
            step(1, 5'(20 + k), 32'h300 + k, 1, 5'(1 + k), 32'h100 + 32'(k + 1), 1, 5'(20 + k), 32'h300 + k);
            check("stall_fill", 32'(wb_is_stall), 32'(k >= 4));
        end
        for (int j = 0; j < 6; j++) begin
            idle(1, 5'(1 + j), 32'h100 + 32'(j + 1));
            check("stall_drain", 32'(wb_is_stall), 32'(j <= 2));
        end
        idle(0, 5'd0, 32'h0);

        phase = "overflow";
        for (int k = 0; k < 9; k++) begin
            step(1, 5'(16 + k), 32'h400 + k, 1, 5'(1 + k), 32'h200 + 32'(k + 1), 1, 5'(16 + k), 32'h400 + k);
            check("ovf_fill", 32'(wb_overflow), 32'(k >= 8));
        end
        // Full FIFO: pop of r1 and push of r10 share the cycle, so r10 must survive
        step(0, 5'd0, 32'h0, 1, 5'd10, 32'h99, 1, 5'd1, 32'h201);
        for (int j = 2; j <= 8; j++)
            idle(1, 5'(j), 32'h200 + 32'(j));
        idle(1, 5'd10, 32'h99);
        idle(0, 5'd0, 32'h0);
        check("ovf_sticky", 32'(wb_overflow), 32'd1);

        phase = "reg_zero";
        step(1, 5'd0, 32'h55, 1, 5'd0, 32'h66, 0, 5'd0, 32'h0);
        idle(0, 5'd0, 32'h0);

        phase = "mid_reset";
        step(1, 5'd20, 32'h500, 1, 5'd1, 32'h601, 1, 5'd20, 32'h500);
        step(1, 5'd21, 32'h501, 1, 5'd2, 32'h602, 1, 5'd21, 32'h501);
        step(1, 5'd22, 32'h502, 1, 5'd3, 32'h603, 1, 5'd22, 32'h502);
        x_wb_writereg = 1'b0;
        y_wb_writereg = 1'b0;
        reset = 1'b0;
        #1;
        check_all_zero();
        last_r = '0;
        last_v = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        idle(0, 5'd0, 32'h0);
        idle(0, 5'd0, 32'h0);
        idle(0, 5'd0, 32'h0);
        idle(0, 5'd0, 32'h0);
        check("post_rst_overflow", 32'(wb_overflow), 32'd0);
        check("post_rst_stall", 32'(wb_is_stall), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
